userdma_dataflow_fifo: RTL

- Show-ahead FIFO channel between dataflow processes in userdma, e.g. the getinstream→streamtoparallelwithburst inbuf channel and the paralleltostreamwithburst→sendoutstream outbuf channel.
- Implements the ap_fifo handshake and produces the per-side blocking indicators (active-low blk_n) that the deadlock monitor consumes.
- Provides occupancy, high-water and sticky protocol-error status for debug.

---
 rtl/userdma_dataflow_fifo.sv | 103 ++++++++++
 1 files changed

// File: rtl/userdma_dataflow_fifo.sv
`default_nettype none
// ============================================================================
// Module   : userdma_dataflow_fifo
// Brief    : Show-ahead ap_fifo channel between userdma dataflow processes,
//            with per-side blocking indicators and debug status.
// Revision : 1.0 - initial release
// ============================================================================
module userdma_dataflow_fifo #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst,
    input  logic [DATA_WIDTH-1:0] if_din,
    input  logic                  if_write,
    output logic                  if_full_n,
    output logic [DATA_WIDTH-1:0] if_dout,
    input  logic                  if_read,
    output logic                  if_empty_n,
    output logic                  wr_blk_n,
    output logic                  rd_blk_n,
    output logic [ADDR_WIDTH:0]   count,
    output logic [ADDR_WIDTH:0]   max_count,
    output logic                  overflow_err,
    output logic                  underflow_err
);

    localparam logic [ADDR_WIDTH:0]   c_depth   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   c_cnt_one = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ptr_one = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_count;
    logic [ADDR_WIDTH:0]   r_max_count;
    logic                  r_empty_n;
    logic                  r_full_n;
    logic                  r_overflow;
    logic                  r_underflow;

    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic [ADDR_WIDTH:0]   w_count_nxt;

    always_comb begin
        w_wr_acc    = if_write & r_full_n;
        w_rd_acc    = if_read & r_empty_n;
        w_count_nxt = r_count;
        case ({w_wr_acc, w_rd_acc})
            2'b10:   w_count_nxt = r_count + c_cnt_one;
            2'b01:   w_count_nxt = r_count - c_cnt_one;
            default: w_count_nxt = r_count;
        endcase
    end

    // Flags are registered from the next count so they are glitch-free outputs.
    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_max_count <= '0;
            r_empty_n   <= 1'b0;
            r_full_n    <= 1'b1;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            if (w_wr_acc)
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            if (w_rd_acc)
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            r_count   <= w_count_nxt;
            r_empty_n <= (w_count_nxt != '0);
            r_full_n  <= (w_count_nxt != c_depth);
            if (w_count_nxt > r_max_count)
                r_max_count <= w_count_nxt;
            if (if_write & ~r_full_n)
                r_overflow <= 1'b1;
            if (if_read & ~r_empty_n)
                r_underflow <= 1'b1;
        end
    end

    // Storage is deliberately left out of reset; the flags gate its visibility.
    always_ff @(posedge ap_clk) begin
        if (w_wr_acc)
            r_mem[r_wr_ptr] <= if_din;
    end

    assign if_dout       = r_empty_n ? r_mem[r_rd_ptr] : '0;
    assign if_full_n     = r_full_n;
    assign if_empty_n    = r_empty_n;
    assign wr_blk_n      = ~(if_write & ~r_full_n);
    assign rd_blk_n      = ~(if_read & ~r_empty_n);
    assign count         = r_count;
    assign max_count     = r_max_count;
    assign overflow_err  = r_overflow;
    assign underflow_err = r_underflow;

endmodule
`default_nettype wire
